// File: rtl/ram_sp_clk_banked_bw.sv
// ram_sp_clk_banked_bw: banked simple-dual-port RAM with byte enables, bypass, optional output register and range checking
module ram_sp_clk_banked_bw #(
  parameter int DW         = 64,
  parameter int DEPTH      = 2880,
  parameter int BANK_DEPTH = 512,
  parameter int OREG       = 0,
  parameter int BYPASS     = 1,
  parameter int AW         = $clog2(DEPTH),
  parameter int NB         = (DEPTH + BANK_DEPTH - 1) / BANK_DEPTH
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            wr_en_i,
  input  logic [AW-1:0]   wr_addr_i,
  input  logic [DW/8-1:0] ben_i,
  input  logic [DW-1:0]   wr_data_i,
  input  logic            rd_en_i,
  input  logic [AW-1:0]   rd_addr_i,
  output logic [DW-1:0]   rd_data_o,
  output logic            rd_valid_o,
  output logic            err_o
);
  localparam int NBY = DW / 8;
  localparam int SH  = $clog2(BANK_DEPTH);
  localparam int OW  = (SH > 0) ? SH : 1;
  localparam int BW  = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);
  logic                   wr_in, rd_in, hit;
  logic [BW-1:0]          wr_bank, rd_bank;
  logic [OW-1:0]          wr_off, rd_off;
  logic [NB-1:0]          wr_sel, rd_sel;
  logic [NB-1:0][DW-1:0]  bank_rd;
  logic [NB-1:0]          sel_d, sel_q;
  logic [NBY-1:0]         byp_be_d, byp_be_q;
  logic [DW-1:0]          byp_data_d, byp_data_q;
  logic [DW-1:0]          mux, merged, dout_d, dout_q;
  logic                   vld1_d, vld1_q, vld2_d, vld2_q, err_d, err_q;
  // address range check and one-hot bank decode for both ports
  always_comb begin
    wr_in   = {1'b0, wr_addr_i} < DEPTH_L;
    rd_in   = {1'b0, rd_addr_i} < DEPTH_L;
    wr_bank = BW'(wr_addr_i >> SH);
    rd_bank = BW'(rd_addr_i >> SH);
    wr_off  = OW'(wr_addr_i);
    rd_off  = OW'(rd_addr_i);
    wr_sel  = '0;
    rd_sel  = '0;
    for (int b = 0; b < NB; b++) begin
      wr_sel[b] = wr_en_i & wr_in & (wr_bank == BW'(b));
      rd_sel[b] = rd_en_i & rd_in & (rd_bank == BW'(b));
    end
    hit = wr_en_i & rd_en_i & wr_in & (wr_addr_i == rd_addr_i);
  end
  // every bank is a full BANK_DEPTH array; words at or above DEPTH in the last bank are never enabled
  for (genvar b = 0; b < NB; b++) begin : g_bank
    logic [DW-1:0] mem_q [BANK_DEPTH];
    logic [DW-1:0] rd_q;
    // byte-masked write into the addressed bank only
    always_ff @(posedge clk) begin
      for (int k = 0; k < NBY; k++)
        if (wr_sel[b] && ben_i[k]) mem_q[wr_off][8*k +: 8] <= wr_data_i[8*k +: 8];
    end
    // read-before-write: a colliding read sees the old word here
    always_ff @(posedge clk) begin
      if (rd_sel[b]) rd_q <= mem_q[rd_off];
    end
    assign bank_rd[b] = rd_q;
  end
  // read pipeline next state, bank AND-OR mux and bypass byte merge
  always_comb begin
    sel_d      = rd_en_i ? rd_sel : sel_q;
    byp_be_d   = rd_en_i ? ((BYPASS != 0 && hit) ? ben_i : '0) : byp_be_q;
    byp_data_d = rd_en_i ? wr_data_i : byp_data_q;
    vld1_d     = rd_en_i;
    vld2_d     = vld1_q;
    err_d      = err_q | (wr_en_i & ~wr_in) | (rd_en_i & ~rd_in);
    mux        = '0;
    for (int b = 0; b < NB; b++) mux = mux | (bank_rd[b] & {DW{sel_q[b]}});
    merged = mux;
    for (int k = 0; k < NBY; k++)
      merged[8*k +: 8] = byp_be_q[k] ? byp_data_q[8*k +: 8] : mux[8*k +: 8];
    dout_d = vld1_q ? merged : dout_q;
  end
  // pipeline registers; an out-of-range read leaves the select all-zero so it returns 0
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sel_q      <= '0;
      byp_be_q   <= '0;
      byp_data_q <= '0;
      vld1_q     <= 1'b0;
      vld2_q     <= 1'b0;
      dout_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      sel_q      <= sel_d;
      byp_be_q   <= byp_be_d;
      byp_data_q <= byp_data_d;
      vld1_q     <= vld1_d;
      vld2_q     <= vld2_d;
      dout_q     <= dout_d;
      err_q      <= err_d;
    end
  end
  assign rd_data_o  = (OREG != 0) ? dout_q : merged;
  assign rd_valid_o = (OREG != 0) ? vld2_q : vld1_q;
  assign err_o      = err_q;
endmodule

// File: tb/tb_ram_sp_clk_banked_bw.sv
// tb_ram_sp_clk_banked_bw: directed checks on the default RAM plus random checks on four small variants
module tb_ram_sp_clk_banked_bw;
  logic        clk, resetn;
  logic        b_we, b_re, b_vld, b_err;
  logic [11:0] b_wa, b_ra;
  logic [7:0]  b_be;
  logic [63:0] b_wd, b_rd;
  logic        s_we, s_re;
  logic [9:0]  s_wa, s_ra;
  logic [3:0]  s_be;
  logic [31:0] s_wd;
  logic [3:0][31:0] s_rd;
  logic [3:0]  s_vld, s_err;
  int n_tests = 0, n_fail = 0;
  logic [31:0] m [1000];
  logic        hv [2];
  logic [31:0] hd0 [2], hd1 [2], last [4];
  logic        sm_err;
  ram_sp_clk_banked_bw u_big (
    .clk(clk), .resetn(resetn), .wr_en_i(b_we), .wr_addr_i(b_wa), .ben_i(b_be), .wr_data_i(b_wd),
    .rd_en_i(b_re), .rd_addr_i(b_ra), .rd_data_o(b_rd), .rd_valid_o(b_vld), .err_o(b_err)
  );
  for (genvar g = 0; g < 4; g++) begin : g_s
    ram_sp_clk_banked_bw #(.DW(32), .DEPTH(1000), .BANK_DEPTH(256), .OREG(g / 2), .BYPASS(g % 2)) u_s (
      .clk(clk), .resetn(resetn), .wr_en_i(s_we), .wr_addr_i(s_wa), .ben_i(s_be), .wr_data_i(s_wd),
      .rd_en_i(s_re), .rd_addr_i(s_ra), .rd_data_o(s_rd[g]), .rd_valid_o(s_vld[g]), .err_o(s_err[g])
    );
  end
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic b_op(input logic we, input logic [11:0] wa, input logic [7:0] be, input logic [63:0] wd,
                      input logic re, input logic [11:0] ra);
    b_we = we; b_wa = wa; b_be = be; b_wd = wd; b_re = re; b_ra = ra;
    @(posedge clk);
    #1;
    b_we = 0; b_re = 0;
  endtask
  task automatic s_cycle(input logic we, input logic [9:0] wa, input logic [3:0] be, input logic [31:0] wd,
                         input logic re, input logic [9:0] ra);
    logic [31:0] old, byp;
    s_we = we; s_wa = wa; s_be = be; s_wd = wd; s_re = re; s_ra = ra;
    @(posedge clk);
    old = (re && ra < 10'd1000) ? m[ra] : 32'h0;
    byp = old;
    if (we && re && wa == ra && wa < 10'd1000)
      for (int k = 0; k < 4; k++) if (be[k]) byp[8*k +: 8] = wd[8*k +: 8];
    if (we && wa < 10'd1000)
      for (int k = 0; k < 4; k++) if (be[k]) m[wa][8*k +: 8] = wd[8*k +: 8];
    if ((we && wa >= 10'd1000) || (re && ra >= 10'd1000)) sm_err = 1;
    hv[1] = hv[0]; hd0[1] = hd0[0]; hd1[1] = hd1[0];
    hv[0] = re; hd0[0] = old; hd1[0] = byp;
    #1;
    for (int g = 0; g < 4; g++) begin
      int o;
      o = g / 2;
      if (hv[o]) last[g] = (g % 2 == 1) ? hd1[o] : hd0[o];
      check($sformatf("s%0d_vld", g), 64'(s_vld[g]), 64'(hv[o]));
      check($sformatf("s%0d_data", g), 64'(s_rd[g]), 64'(last[g]));
      check($sformatf("s%0d_err", g), 64'(s_err[g]), 64'(sm_err));
    end
    s_we = 0; s_re = 0;
  endtask
  initial begin
    logic        we, re;
    logic [9:0]  wa, ra;
    resetn = 0;
    b_we = 1; b_wa = 0; b_be = '1; b_wd = 64'h0123_4567_89AB_CDEF; b_re = 1; b_ra = 0;
    s_we = 0; s_wa = 0; s_be = 0; s_wd = 0; s_re = 0; s_ra = 0;
    hv[0] = 0; hv[1] = 0; hd0[0] = 0; hd0[1] = 0; hd1[0] = 0; hd1[1] = 0; sm_err = 0;
    for (int g = 0; g < 4; g++) last[g] = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data", b_rd, 64'h0);
    check("rst_vld", 64'(b_vld), 64'h0);
    check("rst_err", 64'(b_err), 64'h0);
    check("rst_s3_vld", 64'(s_vld[3]), 64'h0);
    resetn = 1; b_we = 0; b_re = 0;
    @(posedge clk);
    #1;
    check("post_rst_vld", 64'(b_vld), 64'h0);
    b_op(0, 0, 0, 0, 1, 0);
    check("first_vld", 64'(b_vld), 64'h1);
    b_op(0, 0, 0, 0, 0, 0);
    check("vld_pulse", 64'(b_vld), 64'h0);
    b_op(1, 5, 8'hFF, 64'h1111_1111_1111_1111, 0, 0);
    b_op(1, 5, 8'h0F, 64'hFFEE_DDCC_BBAA_9900, 0, 0);
    b_op(0, 0, 0, 0, 1, 5);
    check("ben_vld", 64'(b_vld), 64'h1);
    check("ben_data", b_rd, 64'h1111_1111_BBAA_9900);
    b_op(0, 0, 0, 0, 0, 0);
    check("hold_vld", 64'(b_vld), 64'h0);
    check("hold_data", b_rd, 64'h1111_1111_BBAA_9900);
    b_op(1, 511, 8'hFF, 64'hAAAA_0000_0000_0511, 0, 0);
    b_op(1, 512, 8'hFF, 64'hBBBB_0000_0000_0512, 0, 0);
    b_op(1, 2879, 8'hFF, 64'hCCCC_0000_0000_2879, 0, 0);
    b_op(0, 0, 0, 0, 1, 511);
    check("bank_a", b_rd, 64'hAAAA_0000_0000_0511);
    b_op(0, 0, 0, 0, 1, 512);
    check("bank_b_vld", 64'(b_vld), 64'h1);
    check("bank_b", b_rd, 64'hBBBB_0000_0000_0512);
    b_op(0, 0, 0, 0, 1, 2879);
    check("bank_c_vld", 64'(b_vld), 64'h1);
    check("bank_c", b_rd, 64'hCCCC_0000_0000_2879);
    b_op(1, 100, 8'hFF, 64'h0, 0, 0);
    b_op(1, 100, 8'h01, 64'hAAAA_AAAA_AAAA_AAAA, 1, 100);
    check("coll_byp", b_rd, 64'h0000_0000_0000_00AA);
    b_op(0, 0, 0, 0, 1, 100);
    check("coll_after", b_rd, 64'h0000_0000_0000_00AA);
    b_op(1, 0, 8'hFF, 64'hD0D0_D0D0_0000_0000, 0, 0);
    check("err_clean", 64'(b_err), 64'h0);
    b_op(1, 2880, 8'hFF, 64'hDEAD_BEEF_DEAD_BEEF, 0, 0);
    check("err_wr", 64'(b_err), 64'h1);
    b_op(0, 0, 0, 0, 1, 2880);
    check("oor_vld", 64'(b_vld), 64'h1);
    check("oor_data", b_rd, 64'h0);
    b_op(0, 0, 0, 0, 1, 0);
    check("oor_addr0", b_rd, 64'hD0D0_D0D0_0000_0000);
    check("err_sticky", 64'(b_err), 64'h1);
    for (int a = 0; a < 1000; a++) s_cycle(1, 10'(a), 4'hF, $urandom, 0, 0);
    s_cycle(1, 100, 4'hF, 32'h0, 0, 0);
    s_cycle(1, 100, 4'h1, 32'hAAAA_AAAA, 1, 100);
    check("s_coll_byp0", 64'(s_rd[0]), 64'h0);
    check("s_coll_byp1", 64'(s_rd[1]), 64'hAA);
    s_cycle(0, 0, 0, 0, 1, 100);
    check("s_coll_oreg_byp0", 64'(s_rd[2]), 64'h0);
    check("s_coll_oreg_byp1", 64'(s_rd[3]), 64'hAA);
    check("s_coll_after", 64'(s_rd[0]), 64'hAA);
    for (int i = 0; i < 10000; i++) begin
      we = 1'($urandom_range(0, 1));
      re = 1'($urandom_range(0, 1));
      wa = ($urandom_range(0, 31) == 0) ? 10'($urandom_range(1000, 1023)) : 10'($urandom_range(0, 999));
      ra = ($urandom_range(0, 3) == 0) ? wa :
           ($urandom_range(0, 31) == 0) ? 10'($urandom_range(1000, 1023)) : 10'($urandom_range(0, 999));
      s_cycle(we, wa, 4'($urandom), $urandom, re, ra);
    end
    b_op(0, 0, 0, 0, 1, 0);
    b_re = 1; b_ra = 0;
    #2 resetn = 0;
    #1;
    check("mid_rst_vld", 64'(b_vld), 64'h0);
    check("mid_rst_data", b_rd, 64'h0);
    check("mid_rst_err", 64'(b_err), 64'h0);
    @(posedge clk);
    #1;
    check("mid_rst_hold", 64'(b_vld), 64'h0);
    b_re = 0;
    resetn = 1;
    @(posedge clk);
    #1;
    check("mid_rst_drop", 64'(b_vld), 64'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
